// File: rtl/rs_pkg.sv
// rs_pkg: shared constants and sequencer state encoding for the row-stationary array feeder
package rs_pkg;
  localparam int DW = 8;
  localparam int K = 5;
  localparam int PE_ROWS = 5;
  localparam int PE_COLS = 3;
  localparam int F_ROWS = PE_ROWS + PE_COLS - 1;
  typedef enum logic [2:0] {IDLE, LOAD_W, FILL, COMPUTE, SHIFT, DRAIN, DONE} state_t;
endpackage

// File: rtl/rs_skew_reg.sv
// rs_skew_reg: DEPTH-stage delay line with sync reset (clk, rst, d in, q = d delayed DEPTH cycles)
module rs_skew_reg #(
  parameter int DEPTH = 1,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);
  logic [DW-1:0] pipe [DEPTH];
  always_ff @(posedge clk) begin
    if (rst) pipe <= '{default: '0};
    else begin
      pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign q = pipe[DEPTH-1];
endmodule

// File: rtl/rs_array_feeder.sv
// rs_array_feeder: loads a 5x5 filter and 7-row ifmap strip via valid/ready streams, drives fmaps/weights/worken/outputen of the 5x3 PE array
module rs_array_feeder
  import rs_pkg::*;
#(
  parameter int IW = 16,
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  input  logic            w_valid,
  output logic            w_ready,
  input  logic [5*DW-1:0] w_data,
  input  logic            f_valid,
  output logic            f_ready,
  input  logic [7*DW-1:0] f_data,
  output logic            worken,
  output logic            outputen,
  output logic [DW-1:0]   fmaps_in1_1,
  output logic [DW-1:0]   fmaps_in2_1,
  output logic [DW-1:0]   fmaps_in3_1,
  output logic [DW-1:0]   fmaps_in4_1,
  output logic [DW-1:0]   fmaps_in5_1,
  output logic [DW-1:0]   fmaps_in5_2,
  output logic [DW-1:0]   fmaps_in5_3,
  output logic [DW-1:0]   weight_in1,
  output logic [DW-1:0]   weight_in2,
  output logic [DW-1:0]   weight_in3,
  output logic [DW-1:0]   weight_in4,
  output logic [DW-1:0]   weight_in5
);
  localparam int OW = IW - 4;
  localparam int XW = $clog2(IW);
  localparam logic [XW-1:0] XLAST = XW'(OW - 1);
  state_t state;
  logic [2:0] col_cnt, k_cnt;
  logic [XW-1:0] x_cnt;
  logic [DW-1:0] win [K][F_ROWS];
  logic [DW-1:0] wgt [K][K];
  logic [DW-1:0] fm [K];
  logic [DW-1:0] wt [K];
  logic [DW-1:0] r5, r6;
  logic last_beat;
  assign last_beat = col_cnt == 3'd4;
  // filter and window are both shift-in-at-4 buffers, so FILL and SHIFT share one path
  always_ff @(posedge clk) begin
    if (rst) begin
      win <= '{default: '0};
      wgt <= '{default: '0};
    end else begin
      if (w_valid && w_ready) begin
        for (int c = 0; c < K-1; c++) wgt[c] <= wgt[c+1];
        for (int r = 0; r < K; r++) wgt[K-1][r] <= w_data[DW*r +: DW];
      end
      if (f_valid && f_ready) begin
        for (int c = 0; c < K-1; c++) win[c] <= win[c+1];
        for (int r = 0; r < F_ROWS; r++) win[K-1][r] <= f_data[DW*r +: DW];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      worken <= 1'b0;
      outputen <= 1'b0;
      w_ready <= 1'b0;
      f_ready <= 1'b0;
      col_cnt <= '0;
      k_cnt <= '0;
      x_cnt <= '0;
      fm <= '{default: '0};
      wt <= '{default: '0};
      r5 <= '0;
      r6 <= '0;
    end else begin
      done <= 1'b0;
      worken <= 1'b0;
      outputen <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= LOAD_W;
          busy <= 1'b1;
          w_ready <= 1'b1;
          col_cnt <= '0;
        end
        LOAD_W: if (w_valid) begin
          col_cnt <= last_beat ? 3'd0 : col_cnt + 3'd1;
          if (last_beat) begin
            state <= FILL;
            w_ready <= 1'b0;
            f_ready <= 1'b1;
          end
        end
        FILL: if (f_valid) begin
          col_cnt <= last_beat ? 3'd0 : col_cnt + 3'd1;
          if (last_beat) begin
            state <= COMPUTE;
            f_ready <= 1'b0;
            k_cnt <= '0;
            x_cnt <= '0;
          end
        end
        COMPUTE: begin
          for (int r = 0; r < K; r++) begin
            fm[r] <= win[k_cnt][r];
            wt[r] <= wgt[k_cnt][r];
          end
          r5 <= win[k_cnt][K];
          r6 <= win[k_cnt][K+1];
          worken <= 1'b1;
          outputen <= k_cnt == 3'd4;
          k_cnt <= k_cnt == 3'd4 ? 3'd0 : k_cnt + 3'd1;
          if (k_cnt == 3'd4) begin
            state <= x_cnt == XLAST ? DRAIN : SHIFT;
            f_ready <= x_cnt != XLAST;
          end
        end
        SHIFT: if (f_valid) begin
          state <= COMPUTE;
          f_ready <= 1'b0;
          x_cnt <= x_cnt + 1'b1;
        end
        // col_cnt is back at 0 after FILL and idle through COMPUTE, so it times the drain
        DRAIN: begin
          worken <= 1'b1;
          col_cnt <= col_cnt + 3'd1;
          if (col_cnt == 3'd1) begin
            state <= DONE;
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  rs_skew_reg #(.DEPTH(1), .DW(DW)) u_skew5_2 (.clk(clk), .rst(rst), .d(r5), .q(fmaps_in5_2));
  rs_skew_reg #(.DEPTH(2), .DW(DW)) u_skew5_3 (.clk(clk), .rst(rst), .d(r6), .q(fmaps_in5_3));
  assign fmaps_in1_1 = fm[0];
  assign fmaps_in2_1 = fm[1];
  assign fmaps_in3_1 = fm[2];
  assign fmaps_in4_1 = fm[3];
  assign fmaps_in5_1 = fm[4];
  assign weight_in1 = wt[0];
  assign weight_in2 = wt[1];
  assign weight_in3 = wt[2];
  assign weight_in4 = wt[3];
  assign weight_in5 = wt[4];
endmodule
